// File: rtl/security_pkg.sv
// security_pkg
//   Shared definitions for the alarm sequencer slice:
//   - ZONE_W  : default number of sensor zones
//   - state_e : FSM state encoding (3 bits; codes 5..7 are illegal)
//   - max3    : helper used to size the shared countdown counter
package security_pkg;

  localparam int ZONE_W = 4;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/delay_timer.sv
// delay_timer
//   Down counter shared by the exit, entry and siren countdowns.
//   Ports:
//     i_Clk, i_Reset : clock, asynchronous active-high reset
//     i_Load         : load i_Value this clock (takes priority over stepping)
//     i_Value[CW-1:0]: value to load
//     o_Count        : remaining cycles, registered
//     o_Done         : o_Count == 0
//   The counter steps down by one every clock while nonzero and parks at 0,
//   so it can never underflow.
module delay_timer #(
  parameter int CW = 8
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  input  logic          i_Load,
  input  logic [CW-1:0] i_Value,
  output logic [CW-1:0] o_Count,
  output logic          o_Done
);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Count <= '0;
    end else if (i_Load) begin
      o_Count <= i_Value;
    end else if (o_Count != '0) begin
      o_Count <= o_Count - 1'b1;
    end
  end

  assign o_Done = (o_Count == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
//   Arming / alarm state machine of the security system.
//   Ports:
//     i_Clk, i_Reset   : clock, asynchronous active-high reset
//     i_Arm            : debounced arm-switch level; rising edge = arm request
//     i_Disarm         : single-cycle disarm pulse
//     i_Zone           : sensor levels, 1 = open/tripped
//     o_State          : current state code (registered)
//     o_Armed          : ARMED or ENTRY_DELAY (decoded from state register)
//     o_Siren          : ALARM (decoded from state register)
//     o_Beep           : EXIT_DELAY or ENTRY_DELAY (decoded from state register)
//     o_Arm_Fault      : one-cycle pulse when an arm request is refused
//     o_Zone_Latched   : zones that tripped while armed
//     o_Count          : remaining cycles of the active countdown, else 0
//   Valid/ready note: there is no handshake; i_Arm is a level sampled every
//   clock and i_Disarm is a pulse that is acted on in the clock it is high.
module alarm_sequencer
  import security_pkg::*;
#(
  parameter int                    NUM_ZONES    = ZONE_W,
  parameter logic [NUM_ZONES-1:0]  ENTRY_MASK   = {{(NUM_ZONES-1){1'b0}}, 1'b1},
  parameter int                    EXIT_CYCLES  = 25_000_000,
  parameter int                    ENTRY_CYCLES = 25_000_000,
  parameter int                    ALARM_CYCLES = 100_000_000,
  parameter int                    CW = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES)) + 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic                 i_Arm,
  input  logic                 i_Disarm,
  input  logic [NUM_ZONES-1:0] i_Zone,
  output logic [2:0]           o_State,
  output logic                 o_Armed,
  output logic                 o_Siren,
  output logic                 o_Beep,
  output logic                 o_Arm_Fault,
  output logic [NUM_ZONES-1:0] o_Zone_Latched,
  output logic [CW-1:0]        o_Count
);

  localparam logic [CW-1:0] EXIT_LOAD  = CW'(EXIT_CYCLES - 1);
  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_CYCLES - 1);
  localparam logic [CW-1:0] ALARM_LOAD = CW'(ALARM_CYCLES - 1);

  state_e               state_q;
  state_e               state_d;
  logic                 r_Arm;
  logic                 arm_req;
  logic                 zone_any;
  logic                 zone_instant;
  logic                 zone_door;
  logic                 tmr_load;
  logic [CW-1:0]        tmr_value;
  logic                 tmr_done;
  logic                 latch_clr;
  logic [NUM_ZONES-1:0] latch_set;

  assign arm_req      = i_Arm & ~r_Arm;
  assign zone_any     = |i_Zone;
  assign zone_instant = |(i_Zone & ~ENTRY_MASK);
  assign zone_door    = |(i_Zone & ENTRY_MASK);

  delay_timer #(.CW(CW)) u_timer (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Load  (tmr_load),
    .i_Value (tmr_value),
    .o_Count (o_Count),
    .o_Done  (tmr_done)
  );

  // State register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_q <= ST_DISARMED;
    else         state_q <= state_d;
  end

  // Next-state logic. Leaving a countdown early (disarm, illegal recovery)
  // reloads the timer with 0 so o_Count reads 0 whenever nothing is running.
  // A disarm wins over everything, including latching zones in that clock.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    latch_clr = 1'b0;
    latch_set = '0;
    case (state_q)
      ST_DISARMED: begin
        if (arm_req && !zone_any) begin
          state_d   = ST_EXIT_DELAY;
          tmr_load  = 1'b1;
          tmr_value = EXIT_LOAD;
          latch_clr = 1'b1;
        end
      end
      ST_EXIT_DELAY: begin
        if (i_Disarm) begin
          state_d  = ST_DISARMED;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_Disarm) begin
          state_d  = ST_DISARMED;
          tmr_load = 1'b1;
        end else if (zone_instant) begin
          state_d   = ST_ALARM;
          tmr_load  = 1'b1;
          tmr_value = ALARM_LOAD;
          latch_set = i_Zone;
        end else if (zone_door) begin
          state_d   = ST_ENTRY_DELAY;
          tmr_load  = 1'b1;
          tmr_value = ENTRY_LOAD;
          latch_set = i_Zone;
        end
      end
      ST_ENTRY_DELAY: begin
        if (i_Disarm) begin
          state_d  = ST_DISARMED;
          tmr_load = 1'b1;
        end else begin
          latch_set = i_Zone;
          if (zone_instant || tmr_done) begin
            state_d   = ST_ALARM;
            tmr_load  = 1'b1;
            tmr_value = ALARM_LOAD;
          end
        end
      end
      ST_ALARM: begin
        if (i_Disarm) begin
          state_d  = ST_DISARMED;
          tmr_load = 1'b1;
        end else begin
          latch_set = i_Zone;
          if (tmr_done) state_d = ST_ARMED;
        end
      end
      default: begin
        state_d  = ST_DISARMED;
        tmr_load = 1'b1;
      end
    endcase
  end

  // Output decode straight from the state register (glitch-free).
  always_comb begin
    o_State = state_q;
    o_Armed = (state_q == ST_ARMED) || (state_q == ST_ENTRY_DELAY);
    o_Siren = (state_q == ST_ALARM);
    o_Beep  = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY);
  end

  // Arm edge detect, refused-arm pulse and zone latch.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Arm          <= 1'b0;
      o_Arm_Fault    <= 1'b0;
      o_Zone_Latched <= '0;
    end else begin
      r_Arm       <= i_Arm;
      o_Arm_Fault <= (state_q == ST_DISARMED) && arm_req && zone_any;
      if (latch_clr) o_Zone_Latched <= '0;
      else           o_Zone_Latched <= o_Zone_Latched | latch_set;
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
//   Directed scenarios followed by randomized traffic, all compared every
//   clock against a deadline-based reference model of the alarm rules.
module tb_alarm_sequencer;

  localparam int              NZ    = 4;
  localparam int              EXIT  = 5;
  localparam int              ENTRY = 4;
  localparam int              ALRM  = 6;
  localparam int              CW    = 4;   // $clog2(6) + 1
  localparam logic [NZ-1:0]   MASK  = 4'b0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          disarm;
  logic [NZ-1:0] zone;
  logic [2:0]    st;
  logic          armed, siren, beep, fault;
  logic [NZ-1:0] latched;
  logic [CW-1:0] count;

  alarm_sequencer #(
    .NUM_ZONES    (NZ),
    .ENTRY_MASK   (MASK),
    .EXIT_CYCLES  (EXIT),
    .ENTRY_CYCLES (ENTRY),
    .ALARM_CYCLES (ALRM)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Arm          (arm),
    .i_Disarm       (disarm),
    .i_Zone         (zone),
    .o_State        (st),
    .o_Armed        (armed),
    .o_Siren        (siren),
    .o_Beep         (beep),
    .o_Arm_Fault    (fault),
    .o_Zone_Latched (latched),
    .o_Count        (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each countdown is a deadline in absolute edge numbers.
  // A countdown started at edge s with length L expires at edge s+L, and the
  // count visible after edge n is (deadline - n - 1).
  int            n = 0;
  int            m_phase;   // 0 disarmed,1 exit,2 armed,3 entry,4 alarm
  int            m_end;
  logic [NZ-1:0] m_latch;
  bit            m_prev;
  bit            m_fault;

  task automatic model_reset();
    m_phase = 0;
    m_end   = 0;
    m_latch = '0;
    m_prev  = 0;
    m_fault = 0;
  endtask

  task automatic model_step(input bit a, input bit d, input logic [NZ-1:0] z);
    bit req, inst, door;
    req     = a && !m_prev;
    m_prev  = a;
    m_fault = 0;
    inst    = (z & ~MASK) != 0;
    door    = (z & MASK) != 0;
    case (m_phase)
      0: if (req) begin
           if (z == 0) begin m_phase = 1; m_end = n + EXIT; m_latch = '0; end
           else m_fault = 1;
         end
      1: if (d) m_phase = 0;
         else if (n == m_end) m_phase = 2;
      2: if (d) m_phase = 0;
         else if (inst) begin m_phase = 4; m_end = n + ALRM; m_latch |= z; end
         else if (door) begin m_phase = 3; m_end = n + ENTRY; m_latch |= z; end
      3: if (d) m_phase = 0;
         else begin
           m_latch |= z;
           if (inst || n == m_end) begin m_phase = 4; m_end = n + ALRM; end
         end
      default: if (d) m_phase = 0;
         else begin
           m_latch |= z;
           if (n == m_end) m_phase = 2;
         end
    endcase
  endtask

  function automatic int m_count();
    if (m_phase == 1 || m_phase == 3 || m_phase == 4) return m_end - n - 1;
    return 0;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".state"}, 32'(st),      32'(m_phase));
    check({tag, ".armed"}, 32'(armed),   32'(m_phase == 2 || m_phase == 3));
    check({tag, ".siren"}, 32'(siren),   32'(m_phase == 4));
    check({tag, ".beep"},  32'(beep),    32'(m_phase == 1 || m_phase == 3));
    check({tag, ".fault"}, 32'(fault),   32'(m_fault));
    check({tag, ".latch"}, 32'(latched), 32'(m_latch));
    check({tag, ".count"}, 32'(count),   32'(m_count()));
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick(input bit a, input bit d, input logic [NZ-1:0] z);
    arm    = a;
    disarm = d;
    zone   = z;
    @(posedge clk);
    n++;
    model_step(a, d, z);
    #1;
    compare_all("tick");
  endtask

  // Reset asserted mid-cycle: outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    n++;
    #1;
    rst = 1'b0;
  endtask

  task automatic arm_seq();
    tick(0, 0, '0);
    tick(1, 0, '0);
    repeat (EXIT) tick(1, 0, '0);
  endtask

  initial begin
    rst    = 1'b1;
    arm    = 1'b0;
    disarm = 1'b0;
    zone   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    n += 2;
    #1;
    compare_all("reset");
    check("reset.state_lit", 32'(st), 32'd0);
    rst = 1'b0;

    // exit delay: beep for EXIT clocks, then armed
    tick(1, 0, '0);
    check("exit.state_lit", 32'(st), 32'd1);
    check("exit.count_lit", 32'(count), 32'(EXIT - 1));
    repeat (EXIT - 1) begin
      tick(1, 0, '0);
      check("exit.beep_lit", 32'(beep), 32'd1);
    end
    tick(1, 0, '0);
    check("armed.state_lit", 32'(st), 32'd2);
    check("armed.armed_lit", 32'(armed), 32'd1);

    // refused arm with a zone open
    tick(1, 1, '0);
    tick(0, 0, 4'b0100);
    tick(1, 0, 4'b0100);
    check("fault.pulse_lit", 32'(fault), 32'd1);
    check("fault.state_lit", 32'(st), 32'd0);
    tick(1, 0, 4'b0100);
    check("fault.oneshot_lit", 32'(fault), 32'd0);

    // entry delay, disarm at count 2
    arm_seq();
    tick(1, 0, 4'b0001);
    check("entry.state_lit", 32'(st), 32'd3);
    tick(1, 0, 4'b0001);
    check("entry.count2_lit", 32'(count), 32'd2);
    tick(1, 1, '0);
    check("entry_dis.state_lit", 32'(st), 32'd0);
    check("entry_dis.latch_lit", 32'(latched), 32'b0001);

    // instant zone -> alarm, timeout back to armed with latch kept
    arm_seq();
    tick(1, 0, 4'b0010);
    check("alarm.siren_lit", 32'(siren), 32'd1);
    repeat (ALRM) tick(1, 0, '0);
    check("alarm_to.state_lit", 32'(st), 32'd2);
    check("alarm_to.latch_lit", 32'(latched), 32'b0010);

    // disarm on the same clock as entry expiry
    tick(1, 0, 4'b0001);
    repeat (ENTRY - 1) tick(1, 0, '0);
    check("race.count0_lit", 32'(count), 32'd0);
    tick(1, 1, '0);
    check("race.state_lit", 32'(st), 32'd0);
    check("race.siren_lit", 32'(siren), 32'd0);

    // door and instant zone together -> alarm directly
    arm_seq();
    tick(1, 0, 4'b0011);
    check("both.state_lit", 32'(st), 32'd4);

    // async reset mid exit delay, then a full exit delay again
    tick(1, 1, '0);
    tick(0, 0, '0);
    tick(1, 0, '0);
    tick(1, 0, '0);
    async_reset();
    check("rst_mid.state_lit", 32'(st), 32'd0);
    check("rst_mid.count_lit", 32'(count), 32'd0);
    tick(0, 0, '0);
    tick(1, 0, '0);
    repeat (EXIT - 1) tick(1, 0, '0);
    check("rearm.still_exit_lit", 32'(st), 32'd1);
    tick(1, 0, '0);
    check("rearm.armed_lit", 32'(st), 32'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit            a, d;
      logic [NZ-1:0] z;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        a = ($urandom_range(0, 9) == 0) ? !arm : arm;
        d = ($urandom_range(0, 24) == 0);
        z = ($urandom_range(0, 9) < 7) ? '0 : NZ'($urandom_range(0, 15));
        tick(a, d, z);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
